exe_stage: RTL and testbench

Execute stage of the five-stage ARM pipeline, sitting between the ID/EX pipeline register and the MEM stage. It forms the second operand (Val2) from the shifter operand, runs the ALU and computes the branch target. It also owns the NZCV status register that feeds condition checking in decode. ALU results, store data and control bits are registered into an internal EX/MEM register, so every memory-side output is registered.

---
 rtl/exe_stage.sv | 124 ++++++++++++
 tb/tb_exe_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// Execute stage: forms Val2, runs the ALU, computes the branch target, and
// owns the NZCV status register plus the EX/MEM pipeline register.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic [31:0] pc,
  input  logic [3:0]  alu_cmd,
  input  logic        wb_en,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic        s,
  input  logic        b,
  input  logic        imm,
  input  logic [11:0] shifter_operand,
  input  logic [23:0] signed_imm_24,
  input  logic [3:0]  dest,
  input  logic [31:0] val_rn,
  input  logic [31:0] val_rm,
  output logic [3:0]  sr,
  output logic        branch_taken,
  output logic [31:0] branch_addr,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic        mem_w_en_out,
  output logic [31:0] alu_res,
  output logic [31:0] val_rm_out,
  output logic [3:0]  dest_out
);

  typedef enum logic [3:0] {
    ALU_MOV = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_ADC = 4'b0011,
    ALU_SUB = 4'b0100,
    ALU_SBC = 4'b0101,
    ALU_AND = 4'b0110,
    ALU_ORR = 4'b0111,
    ALU_EOR = 4'b1000,
    ALU_MVN = 4'b1001
  } alu_cmd_e;

  logic [31:0] val2;
  logic [31:0] imm32;
  logic [4:0]  imm_rot;
  logic [4:0]  sh_amt;
  logic [31:0] res;
  logic [31:0] op_b;
  logic        carry_in;
  logic        arith;
  logic [32:0] sum;
  logic        flag_n, flag_z, flag_c, flag_v;

  assign imm32   = {24'b0, shifter_operand[7:0]};
  assign imm_rot = {shifter_operand[11:8], 1'b0};
  assign sh_amt  = shifter_operand[11:7];

  // Rotates use (x >> n) | (x << (32-n)); a zero amount shifts by 32 and yields 0.
  always_comb begin
    val2 = '0;
    if (mem_r_en || mem_w_en) begin
      val2 = {20'b0, shifter_operand};
    end else if (imm) begin
      val2 = (imm32 >> imm_rot) | (imm32 << (6'd32 - {1'b0, imm_rot}));
    end else begin
      case (shifter_operand[6:5])
        2'b00:   val2 = val_rm << sh_amt;
        2'b01:   val2 = val_rm >> sh_amt;
        2'b10:   val2 = $signed(val_rm) >>> sh_amt;
        default: val2 = (val_rm >> sh_amt) | (val_rm << (6'd32 - {1'b0, sh_amt}));
      endcase
    end
  end

  // Subtractions reuse the adder as Rn + ~Val2 + carry, so C is "no borrow".
  always_comb begin
    res      = '0;
    op_b     = val2;
    carry_in = 1'b0;
    arith    = 1'b0;
    case (alu_cmd_e'(alu_cmd))
      ALU_MOV: res = val2;
      ALU_MVN: res = ~val2;
      ALU_ADD: arith = 1'b1;
      ALU_ADC: begin arith = 1'b1; carry_in = sr[1]; end
      ALU_SUB: begin arith = 1'b1; op_b = ~val2; carry_in = 1'b1; end
      ALU_SBC: begin arith = 1'b1; op_b = ~val2; carry_in = sr[1]; end
      ALU_AND: res = val_rn & val2;
      ALU_ORR: res = val_rn | val2;
      ALU_EOR: res = val_rn ^ val2;
      default: res = '0;
    endcase
    sum = {1'b0, val_rn} + {1'b0, op_b} + {32'b0, carry_in};
    if (arith) res = sum[31:0];
    flag_n = res[31];
    flag_z = (res == '0);
    flag_c = arith ? sum[32] : sr[1];
    flag_v = arith ? ((val_rn[31] == op_b[31]) && (res[31] != val_rn[31])) : sr[0];
  end

  assign branch_taken = b;
  assign branch_addr  = pc + {{6{signed_imm_24[23]}}, signed_imm_24, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr           <= '0;
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      mem_w_en_out <= 1'b0;
      alu_res      <= '0;
      val_rm_out   <= '0;
      dest_out     <= '0;
    end else if (!freeze) begin
      if (s) sr <= {flag_n, flag_z, flag_c, flag_v};
      wb_en_out    <= wb_en;
      mem_r_en_out <= mem_r_en;
      mem_w_en_out <= mem_w_en;
      alu_res      <= res;
      val_rm_out   <= val_rm;
      dest_out     <= dest;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: expected EX/MEM contents are queued when an
// operation is driven and compared after the edge that registers it.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic [31:0] pc;
  logic [3:0]  alu_cmd;
  logic        wb_en, mem_r_en, mem_w_en, s, b, imm;
  logic [11:0] shifter_operand;
  logic [23:0] signed_imm_24;
  logic [3:0]  dest;
  logic [31:0] val_rn, val_rm;
  logic [3:0]  sr;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out;
  logic [31:0] alu_res, val_rm_out;
  logic [3:0]  dest_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  sr;
    logic [2:0]  ctl;
    logic [31:0] rm;
    logic [3:0]  dest;
  } exp_t;

  exp_t sb[$];

  exe_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .pc(pc), .alu_cmd(alu_cmd),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .s(s), .b(b),
    .imm(imm), .shifter_operand(shifter_operand), .signed_imm_24(signed_imm_24),
    .dest(dest), .val_rn(val_rn), .val_rm(val_rm), .sr(sr),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .alu_res(alu_res), .val_rm_out(val_rm_out), .dest_out(dest_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [3:0] cmd, input logic s_v, input logic imm_v,
                        input logic [11:0] so, input logic [31:0] rn, input logic [31:0] rm,
                        input logic [3:0] d, input logic wb_v, input logic mr_v, input logic mw_v);
    alu_cmd = cmd; s = s_v; imm = imm_v; shifter_operand = so;
    val_rn = rn; val_rm = rm; dest = d; wb_en = wb_v; mem_r_en = mr_v; mem_w_en = mw_v;
  endtask

  task automatic push(input logic [31:0] r, input logic [3:0] f, input logic [2:0] c,
                      input logic [31:0] rm, input logic [3:0] d);
    exp_t e;
    e.res = r; e.sr = f; e.ctl = c; e.rm = rm; e.dest = d;
    sb.push_back(e);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_alu_res"}, alu_res, e.res);
      check({tag, "_sr"}, {28'b0, sr}, {28'b0, e.sr});
      check({tag, "_ctl"}, {29'b0, wb_en_out, mem_r_en_out, mem_w_en_out}, {29'b0, e.ctl});
      check({tag, "_val_rm"}, val_rm_out, e.rm);
      check({tag, "_dest"}, {28'b0, dest_out}, {28'b0, e.dest});
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sr"}, {28'b0, sr}, 32'd0);
    check({tag, "_alu_res"}, alu_res, 32'd0);
    check({tag, "_ctl"}, {29'b0, wb_en_out, mem_r_en_out, mem_w_en_out}, 32'd0);
    check({tag, "_val_rm"}, val_rm_out, 32'd0);
    check({tag, "_dest"}, {28'b0, dest_out}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; pc = '0; b = 1'b0; signed_imm_24 = '0;
    set_op(4'd0, 1'b0, 1'b0, 12'h000, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // ADD overflow into sign bit
    set_op(4'b0010, 1'b1, 1'b1, 12'h001, 32'h7FFFFFFF, 32'h1234, 4'd3, 1'b1, 1'b0, 1'b0);
    push(32'h80000000, 4'b1001, 3'b100, 32'h1234, 4'd3);
    tick("add_ovf");

    // ADD wrapping to zero: carry out, no overflow
    set_op(4'b0010, 1'b1, 1'b1, 12'h001, 32'hFFFFFFFF, 32'h0, 4'd4, 1'b1, 1'b0, 1'b0);
    push(32'h0, 4'b0110, 3'b100, 32'h0, 4'd4);
    tick("add_wrap");

    set_op(4'b0100, 1'b1, 1'b1, 12'h005, 32'd5, 32'h0, 4'd1, 1'b0, 1'b0, 1'b0);
    push(32'h0, 4'b0110, 3'b000, 32'h0, 4'd1);
    tick("cmp_eq");

    // ADC 1+1 with carry-in 1, flags untouched
    set_op(4'b0011, 1'b0, 1'b1, 12'h001, 32'd1, 32'h0, 4'd2, 1'b1, 1'b0, 1'b0);
    push(32'd3, 4'b0110, 3'b100, 32'h0, 4'd2);
    tick("adc");

    // MOV of rotated immediate: N set, C/V kept
    set_op(4'b0001, 1'b1, 1'b1, 12'h4FF, 32'h0, 32'h0, 4'd6, 1'b1, 1'b0, 1'b0);
    push(32'hFF000000, 4'b1010, 3'b100, 32'h0, 4'd6);
    tick("mov_rot");

    set_op(4'b0001, 1'b0, 1'b0, 12'h143, 32'h0, 32'h80000000, 4'd7, 1'b1, 1'b0, 1'b0);
    push(32'hE0000000, 4'b1010, 3'b100, 32'h80000000, 4'd7);
    tick("mov_asr");

    // 0 - 1: borrow clears C
    set_op(4'b0100, 1'b1, 1'b1, 12'h001, 32'd0, 32'h0, 4'd8, 1'b1, 1'b0, 1'b0);
    push(32'hFFFFFFFF, 4'b1000, 3'b100, 32'h0, 4'd8);
    tick("sub_borrow");

    // SBC with C=0 subtracts an extra 1: 5 - 1 - 1
    set_op(4'b0101, 1'b1, 1'b1, 12'h001, 32'd5, 32'h0, 4'd9, 1'b1, 1'b0, 1'b0);
    push(32'd3, 4'b0010, 3'b100, 32'h0, 4'd9);
    tick("sbc");

    set_op(4'b1000, 1'b1, 1'b0, 12'h000, 32'hF0F0F0F0, 32'hFFFF0000, 4'd10, 1'b1, 1'b0, 1'b0);
    push(32'h0F0FF0F0, 4'b0010, 3'b100, 32'hFFFF0000, 4'd10);
    tick("eor");

    // MVN of Rm ROR #4
    set_op(4'b1001, 1'b0, 1'b0, 12'h260, 32'h0, 32'h000000F1, 4'd11, 1'b1, 1'b0, 1'b0);
    push(32'hEFFFFFF0, 4'b0010, 3'b100, 32'h000000F1, 4'd11);
    tick("mvn_ror");

    set_op(4'b0000, 1'b1, 1'b0, 12'h000, 32'h1234, 32'h0, 4'd12, 1'b0, 1'b0, 1'b0);
    push(32'h0, 4'b0110, 3'b000, 32'h0, 4'd12);
    tick("undef_cmd");

    // Branch target is combinational
    pc = 32'h100; signed_imm_24 = 24'hFFFFFE; b = 1'b1;
    set_op(4'b0000, 1'b0, 1'b0, 12'h000, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("branch_addr", branch_addr, 32'hF8);
    check("branch_taken", {31'b0, branch_taken}, 32'd1);
    push(32'h0, 4'b0110, 3'b000, 32'h0, 4'd0);
    tick("branch");
    b = 1'b0;

    set_op(4'b0010, 1'b0, 1'b0, 12'h004, 32'h400, 32'h55, 4'd5, 1'b1, 1'b1, 1'b0);
    push(32'h404, 4'b0110, 3'b110, 32'h55, 4'd5);
    tick("ldr");

    // Freeze with a flag-setting op pending: everything holds
    freeze = 1'b1;
    set_op(4'b0010, 1'b1, 1'b1, 12'h001, 32'hFFFFFFFF, 32'h99, 4'd13, 1'b1, 1'b0, 1'b0);
    push(32'h404, 4'b0110, 3'b110, 32'h55, 4'd5);
    tick("freeze1");
    set_op(4'b0100, 1'b1, 1'b1, 12'h002, 32'd1, 32'h77, 4'd14, 1'b0, 1'b0, 1'b1);
    pc = 32'h0; signed_imm_24 = 24'h000004;
    #1;
    check("freeze_branch_addr", branch_addr, 32'h10);
    push(32'h404, 4'b0110, 3'b110, 32'h55, 4'd5);
    tick("freeze2");
    freeze = 1'b0;

    // Store: memory offset wins over the immediate bit
    set_op(4'b0010, 1'b0, 1'b1, 12'hFFF, 32'h10, 32'hCAFE, 4'd0, 1'b0, 1'b0, 1'b1);
    push(32'h100F, 4'b0110, 3'b001, 32'hCAFE, 4'd0);
    tick("str");

    // Asynchronous reset mid-cycle, no edge needed
    #3;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    #2;
    rst = 1'b0;

    check("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
